// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch port, data port, memory side and
// status of mem_port_arbiter.
//   slave  : seen by the arbiter (requests in, acks/rdata/memory strobes out)
//   master : seen by the CPU stages plus memory model (the mirror image)
// Signals:
//   if_req/if_addr/if_rdata/if_ack               instruction-fetch port
//   d_req/d_we/d_addr/d_wdata/d_rdata/d_ack      load/store port
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   unified memory port
//   busy                                         arbiter not idle
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between the
// instruction-fetch stage and the load/store stage. One access at a time:
//   IDLE -> ISSUE (mem_en, 1 cycle) -> WAIT (MEM_LAT cycles) -> DONE (ack)
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mem_port_arbiter_if.slave (fetch, data, memory, busy)
// Parameters: AW, DW, MEM_LAT (1..15), STARVE_MAX.
// Optional feature: define MEM_ARB_FAIR_EN to let a starved fetch win a tie
// after STARVE_MAX consecutive data grants; otherwise data always wins ties.
module mem_port_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state, state_nxt;

  logic          gnt_d;      // 1: current access belongs to the data port
  logic          we_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] wdata_r;
  logic [3:0]    lat_cnt;
  logic [DW-1:0] if_rdata_r;
  logic [DW-1:0] d_rdata_r;

  logic          data_wins;  // tie-break: 1 = data port takes a tie
  logic          take_d;
  logic          take_f;
  logic          last_wait;

  // Arbitration is only meaningful in IDLE; the captures below are gated by it.
  assign take_d    = bus.d_req && (!bus.if_req || data_wins);
  assign take_f    = bus.if_req && !take_d;
  assign last_wait = (state == WAIT) && (lat_cnt == 4'd1);

`ifdef MEM_ARB_FAIR_EN
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;

  // Once the fetch has watched SMAX data grants go by, it gets the next tie.
  assign data_wins = (starve_cnt != SMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!bus.if_req || take_f)
        starve_cnt <= '0;
      else if (take_d && starve_cnt != SMAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  // Strict data priority; STARVE_MAX has no effect in this build.
  assign data_wins = 1'b1 | (STARVE_MAX < 0);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.if_req || bus.d_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (lat_cnt == 4'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, latency counter and read-data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_d      <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      lat_cnt    <= '0;
      if_rdata_r <= '0;
      d_rdata_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_d) begin
            gnt_d   <= 1'b1;
            we_r    <= bus.d_we;
            addr_r  <= bus.d_addr;
            wdata_r <= bus.d_wdata;
          end else if (take_f) begin
            // Fetch never writes; wdata keeps its last value.
            gnt_d   <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= bus.if_addr;
          end
        end
        ISSUE: lat_cnt <= 4'(MEM_LAT);
        WAIT:  lat_cnt <= lat_cnt - 4'd1;
        default: ;
      endcase

      // mem_rdata is valid exactly in the last WAIT cycle.
      if (last_wait) begin
        if (!gnt_d)     if_rdata_r <= bus.mem_rdata;
        else if (!we_r) d_rdata_r  <= bus.mem_rdata;
      end
    end
  end

  // Outputs decode directly from registered state, so they are glitch-free
  // and drop to zero the moment reset lands.
  assign bus.mem_en    = (state == ISSUE);
  assign bus.mem_we    = (state == ISSUE) && we_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.if_ack    = (state == DONE) && !gnt_d;
  assign bus.d_ack     = (state == DONE) && gnt_d;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed timing checks plus randomized two-port
// traffic. Stimulus pushes expected read data into per-port queues; a
// negedge monitor pops and compares on every ack.
module tb_mem_port_arbiter;
  localparam int AW = 16, DW = 16, LAT = 2, SMAX = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   en_cyc = 0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus();

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem_arr [logic [15:0]];  // memory responder contents
  logic [15:0] ref_mem [logic [15:0]];  // reference view of data stores
  logic [15:0] if_exp [$];
  logic [15:0] d_exp  [$];
  logic [15:0] d_last = 16'h0;          // expected d_rdata (last load)

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hA5A5 : (a ^ 16'h5A5A);
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic f_start(input logic [15:0] a);
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    if_exp.push_back(init_val(a));
  endtask

  task automatic d_start(input logic we, input logic [15:0] a, input logic [15:0] wd);
    bus.d_we    = we;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    bus.d_req   = 1'b1;
    if (we) ref_mem[a] = wd;
    else    d_last = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    d_exp.push_back(d_last);
  endtask

  // Memory responder: stores write immediately; loads return the word
  // exactly LAT cycles after mem_en and random junk in every other cycle.
  initial begin : mem_model
    int due;
    logic [15:0] rv;
    due = -1;
    rv  = '0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.mem_en) begin
        if (bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
        else begin
          due = cyc + LAT;
          rv  = mem_arr.exists(bus.mem_addr) ? mem_arr[bus.mem_addr] : init_val(bus.mem_addr);
        end
      end
      bus.mem_rdata = (cyc == due) ? rv : 16'($urandom);
    end
  end

  // Scoreboard monitor
  initial begin : monitor
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mem_en) en_cyc = cyc;
        chk("we_without_en", 32'(bus.mem_we && !bus.mem_en), 0);
        chk("dual_ack", 32'(bus.if_ack && bus.d_ack), 0);
        if (bus.if_ack) begin
          if (if_exp.size() == 0) begin
            total++; bad++;
            $display("FAIL if_ack_unexpected: got ack expected none (cycle %0d)", cyc);
          end else begin
            e = if_exp.pop_front();
            chk("if_rdata", 32'(bus.if_rdata), 32'(e));
          end
          chk("if_ack_latency", 32'(cyc - en_cyc), 32'(LAT + 1));
        end
        if (bus.d_ack) begin
          if (d_exp.size() == 0) begin
            total++; bad++;
            $display("FAIL d_ack_unexpected: got ack expected none (cycle %0d)", cyc);
          end else begin
            e = d_exp.pop_front();
            chk("d_rdata", 32'(bus.d_rdata), 32'(e));
          end
          chk("d_ack_latency", 32'(cyc - en_cyc), 32'(LAT + 1));
        end
      end
    end
  end

  task automatic wait_ack(input bit is_d);
    int w;
    w = 0;
    do begin
      step();
      w++;
    end while (!(is_d ? bus.d_ack : bus.if_ack) && w < 1000);
    if (!(is_d ? bus.d_ack : bus.if_ack)) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no ack expected ack within 1000 cycles", is_d ? "d" : "if");
    end
    if (is_d) bus.d_req = 1'b0;
    else      bus.if_req = 1'b0;
  endtask

  task automatic fetch_proc();
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) step();
      f_start(16'($urandom_range(0, 255)));
      wait_ack(1'b0);
    end
  endtask

  task automatic data_proc();
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) step();
      d_start(1'($urandom_range(0, 1)), 16'h0200 + 16'($urandom_range(0, 7) * 2), 16'($urandom));
      wait_ack(1'b1);
    end
  endtask

  initial begin : main
    bit f_turn;
    bus.if_req = 0; bus.if_addr = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;

    // Reset state
    repeat (2) step();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_acks", 32'({bus.if_ack, bus.d_ack}), 0);
    chk("rst_rdata", 32'({bus.if_rdata, bus.d_rdata}), 0);
    chk("rst_mem_bus", 32'({bus.mem_addr, bus.mem_wdata}), 0);
    rst = 1'b0;
    step();

    // Single fetch (cycle 0 = request sampled)
    f_start(16'h0010);
    step(); // c1
    chk("fetch_mem_en", 32'(bus.mem_en), 1);
    chk("fetch_mem_we", 32'(bus.mem_we), 0);
    chk("fetch_mem_addr", 32'(bus.mem_addr), 32'h0010);
    step(); step(); // c3
    chk("fetch_ack_early", 32'(bus.if_ack), 0);
    step(); // c4
    chk("fetch_ack", 32'(bus.if_ack), 1);
    chk("fetch_rdata", 32'(bus.if_rdata), 32'hA5A5);
    bus.if_req = 0;
    step(); // c5
    chk("fetch_busy_done", 32'(bus.busy), 0);

    // Store
    d_start(1'b1, 16'h0200, 16'h1234);
    step();
    chk("store_en_we", 32'({bus.mem_en, bus.mem_we}), 32'h3);
    chk("store_addr", 32'(bus.mem_addr), 32'h0200);
    chk("store_wdata", 32'(bus.mem_wdata), 32'h1234);
    step(); step(); step(); // c4
    chk("store_ack", 32'(bus.d_ack), 1);
    chk("store_rdata_kept", 32'(bus.d_rdata), 0);
    bus.d_req = 0;
    step();

    // Tie: data first, fetch granted at c5, acked at c9
    d_start(1'b0, 16'h0200, 16'h0);
    f_start(16'h0020);
    step(); // c1
    chk("tie_first_addr", 32'(bus.mem_addr), 32'h0200);
    step(); step(); step(); // c4
    chk("tie_d_ack", 32'({bus.d_ack, bus.if_ack}), 32'h2);
    bus.d_req = 0;
    step(); // c5
    chk("tie_idle_c5", 32'(bus.busy), 0);
    step(); // c6
    chk("tie_fetch_issue", 32'({bus.mem_en, bus.mem_addr}), 32'h10020);
    step(); step(); step(); // c9
    chk("tie_if_ack", 32'(bus.if_ack), 1);
    bus.if_req = 0;
    step();

    // Early drop of d_req
    d_start(1'b0, 16'h0200, 16'h0);
    step(); // c1
    bus.d_req = 0;
    step(); step(); step(); // c4
    chk("early_drop_ack", 32'(bus.d_ack), 1);
    step();

    // Reset in cycle 2 of a fetch
    f_start(16'h0030);
    step(); step(); // c2
    rst = 1'b1;
    #1;
    chk("midrst_mem_en", 32'(bus.mem_en), 0);
    chk("midrst_busy_ack", 32'({bus.busy, bus.if_ack, bus.d_ack}), 0);
    chk("midrst_rdata", 32'({bus.if_rdata, bus.d_rdata}), 0);
    chk("midrst_mem_bus", 32'({bus.mem_addr, bus.mem_wdata}), 0);
    d_last = 16'h0;
    step(); step();
    chk("midrst_no_ack", 32'(bus.if_ack), 0);
    rst = 1'b0;
    step();
    chk("midrst_regrant", 32'({bus.mem_en, bus.mem_addr}), 32'h10030);
    step(); step(); step();
    chk("midrst_ack", 32'(bus.if_ack), 1);
    bus.if_req = 0;
    step();

    // Continuous contention: loads of 0x0200 vs fetch of 0x0040
    bus.d_we = 0; bus.d_addr = 16'h0200; bus.d_req = 1;
    bus.if_addr = 16'h0040; bus.if_req = 1;
    for (int k = 0; k < 6; k++) begin
      repeat ((k == 0) ? 3 : 4) step();
`ifdef MEM_ARB_FAIR_EN
      f_turn = (k % 3 == 2);
`else
      f_turn = 1'b0;
`endif
      if (f_turn) if_exp.push_back(init_val(16'h0040));
      else begin d_last = 16'h1234; d_exp.push_back(d_last); end
      step();
      chk("contend_order", 32'({bus.d_ack, bus.if_ack}), f_turn ? 32'h1 : 32'h2);
    end
    bus.d_req = 0;
    repeat (4) step();
    if_exp.push_back(init_val(16'h0040));
    step();
    chk("contend_final_fetch", 32'(bus.if_ack), 1);
    bus.if_req = 0;
    step();

    // Randomized two-port traffic
    fork
      fetch_proc();
      data_proc();
    join
    repeat (4) step();
    chk("if_queue_drained", 32'(if_exp.size()), 0);
    chk("d_queue_drained", 32'(d_exp.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
